// File: rtl/tx_serial_registrado.sv
// tx_serial_registrado: registered asynchronous serial transmitter.
// Captures a parallel word on a start request and shifts it out as a frame:
// start bit, N_DADOS data bits LSB-first, optional even parity, N_PARADA stop
// bits. Every output is driven straight from a flop, so the line never glitches.
// Optional feature: define TX_PARIDADE_EN to compile in the even-parity bit.
module tx_serial_registrado #(
  parameter int N_DADOS  = 8,
  parameter int DIVISOR  = 5208,
  parameter int N_PARADA = 1
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               partida,
  input  logic [N_DADOS-1:0] dados,
  output logic               saida_serial,
  output logic               ocupado,
  output logic               pronto
);

  localparam int BAUD_W = $clog2(DIVISOR);
  localparam int BIT_W  = $clog2(N_DADOS + 1);

  localparam logic [BAUD_W-1:0] BAUD_FIM   = BAUD_W'(DIVISOR - 1);
  localparam logic [BIT_W-1:0]  BIT_FIM    = BIT_W'(N_DADOS - 1);
  localparam logic [BIT_W-1:0]  PARADA_FIM = BIT_W'(N_PARADA - 1);

  typedef enum logic [2:0] {
    REPOUSO  = 3'd0,
    INICIO   = 3'd1,
    DADOS    = 3'd2,
`ifdef TX_PARIDADE_EN
    PARIDADE = 3'd3,
`endif
    PARADA   = 3'd4,
    FINAL    = 3'd5
  } estado_t;

  estado_t             estado, estado_prox;
  logic [BAUD_W-1:0]   baud_cnt, baud_prox;
  logic [BIT_W-1:0]    bit_cnt, bit_prox;
  logic [N_DADOS-1:0]  captura, captura_prox;
  logic                saida_prox, ocupado_prox, pronto_prox;
  logic                fim_baud;

`ifdef TX_PARIDADE_EN
  logic paridade, paridade_prox;
`endif

  assign fim_baud = (baud_cnt == BAUD_FIM);

  // State, counters, capture register and registered outputs.
  // NOTE: the capture register is reset together with the control state so the
  // block comes out of clear with fully defined contents, not just a valid FSM.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      estado       <= REPOUSO;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      captura      <= '0;
      saida_serial <= 1'b1;
      ocupado      <= 1'b0;
      pronto       <= 1'b0;
`ifdef TX_PARIDADE_EN
      paridade     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // values, so the order of these lines does not matter.
      estado       <= estado_prox;
      baud_cnt     <= baud_prox;
      bit_cnt      <= bit_prox;
      captura      <= captura_prox;
      saida_serial <= saida_prox;
      ocupado      <= ocupado_prox;
      pronto       <= pronto_prox;
`ifdef TX_PARIDADE_EN
      paridade     <= paridade_prox;
`endif
    end
  end

  // Next-state, counter and shift-register logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    estado_prox  = estado;
    baud_prox    = baud_cnt + 1'b1;
    bit_prox     = bit_cnt;
    captura_prox = captura;
`ifdef TX_PARIDADE_EN
    paridade_prox = paridade;
`endif
    case (estado)
      REPOUSO: begin
        baud_prox = '0;
        bit_prox  = '0;
        if (partida) begin
          captura_prox = dados;
`ifdef TX_PARIDADE_EN
          paridade_prox = ^dados;
`endif
          estado_prox  = INICIO;
        end
      end
      INICIO: begin
        if (fim_baud) begin
          baud_prox   = '0;
          estado_prox = DADOS;
        end
      end
      DADOS: begin
        if (fim_baud) begin
          baud_prox    = '0;
          captura_prox = captura >> 1;
          if (bit_cnt == BIT_FIM) begin
            bit_prox    = '0;
`ifdef TX_PARIDADE_EN
            estado_prox = PARIDADE;
`else
            estado_prox = PARADA;
`endif
          end else begin
            bit_prox = bit_cnt + 1'b1;
          end
        end
      end
`ifdef TX_PARIDADE_EN
      PARIDADE: begin
        if (fim_baud) begin
          baud_prox   = '0;
          estado_prox = PARADA;
        end
      end
`endif
      PARADA: begin
        // The bit counter is reused to count stop-bit periods.
        if (fim_baud) begin
          baud_prox = '0;
          if (bit_cnt == PARADA_FIM) begin
            bit_prox    = '0;
            estado_prox = FINAL;
          end else begin
            bit_prox = bit_cnt + 1'b1;
          end
        end
      end
      FINAL: begin
        baud_prox   = '0;
        estado_prox = REPOUSO;
      end
      default: begin
        baud_prox   = '0;
        bit_prox    = '0;
        estado_prox = REPOUSO;
      end
    endcase
  end

  // Output values decoded from the upcoming state so the flops line up with it.
  always_comb begin
    saida_prox   = 1'b1;
    ocupado_prox = 1'b0;
    pronto_prox  = 1'b0;
    case (estado_prox)
      INICIO: begin
        saida_prox   = 1'b0;
        ocupado_prox = 1'b1;
      end
      DADOS: begin
        saida_prox   = captura_prox[0];
        ocupado_prox = 1'b1;
      end
`ifdef TX_PARIDADE_EN
      PARIDADE: begin
        saida_prox   = paridade_prox;
        ocupado_prox = 1'b1;
      end
`endif
      PARADA: begin
        ocupado_prox = 1'b1;
      end
      FINAL: begin
        pronto_prox = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
